// File: rtl/decrypt_engine.sv
// Iterative AES-128 inverse cipher: expands the key once into 11 round keys, then
// decrypts one 128-bit block per 11 clocks at one round per clock.
module decrypt_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_key,
    input  logic [127:0] key,
    input  logic         halt,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    output logic [127:0] out,
    output logic         out_valid,
    output logic [1:0]   o_dbg_state
);
    // Handshake: a block is taken on a rising edge where in_valid && in_ready; in_ready
    // does not depend on in_valid, and out_valid is a one-cycle pulse with no back-pressure.
    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_KEY_GEN = 2'd1,
        S_READY   = 2'd2,
        S_BUSY    = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [127:0] r_rk [0:10];
    logic [3:0]   r_kcnt;
    logic [3:0]   r_rnd;
    logic [127:0] r_data;
    logic [127:0] r_out;
    logic         r_out_valid;

    logic [3:0]   w_prev_idx;
    logic [127:0] w_prev_rk;
    logic [31:0]  w_temp;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_rk;
    logic [127:0] w_ark;
    logic [127:0] w_round;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h01;
        t = a;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] y;
        y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox_inv(s[127-8*n -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] rk);
        return s ^ rk;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One full round key per cycle: all four words derived from the previous key.
    assign w_prev_idx = (r_kcnt == 4'd0) ? 4'd0 : r_kcnt - 4'd1;
    assign w_prev_rk  = r_rk[w_prev_idx];
    assign w_temp     = {sbox_fwd(w_prev_rk[23:16]), sbox_fwd(w_prev_rk[15:8]),
                         sbox_fwd(w_prev_rk[7:0]),   sbox_fwd(w_prev_rk[31:24])}
                        ^ {rcon(r_kcnt), 24'h000000};
    assign w_n0       = w_prev_rk[127:96] ^ w_temp;
    assign w_n1       = w_prev_rk[95:64]  ^ w_n0;
    assign w_n2       = w_prev_rk[63:32]  ^ w_n1;
    assign w_n3       = w_prev_rk[31:0]   ^ w_n2;
    assign w_next_rk  = {w_n0, w_n1, w_n2, w_n3};

    assign w_ark   = add_round_key(inv_sub_bytes(inv_shift_rows(r_data)), r_rk[r_rnd]);
    assign w_round = inv_mix_columns(w_ark);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            S_INIT:    if (set_key) w_next_state = S_KEY_GEN;
            S_KEY_GEN: if (r_kcnt == 4'd10) w_next_state = S_READY;
            S_READY: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = S_BUSY;
            end
            S_BUSY:    if (r_rnd == 4'd0) w_next_state = S_READY;
            default:   w_next_state = S_INIT;
        endcase
        if (halt) w_next_state = S_INIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
            r_kcnt      <= 4'd0;
            r_rnd       <= 4'd0;
            r_data      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (halt) begin
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
            r_kcnt      <= 4'd0;
            r_rnd       <= 4'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (set_key) begin
                        r_rk[0] <= key;
                        r_kcnt  <= 4'd1;
                    end
                end
                S_KEY_GEN: begin
                    r_rk[r_kcnt] <= w_next_rk;
                    r_kcnt       <= (r_kcnt == 4'd10) ? 4'd0 : r_kcnt + 4'd1;
                end
                S_READY: begin
                    if (in_valid) begin
                        r_data <= add_round_key(state, r_rk[10]);
                        r_rnd  <= 4'd9;
                    end
                end
                S_BUSY: begin
                    if (r_rnd != 4'd0) begin
                        r_data <= w_round;
                        r_rnd  <= r_rnd - 4'd1;
                    end else begin
                        r_out       <= w_ark;
                        r_out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out         = r_out;
    assign out_valid   = r_out_valid;
    assign o_dbg_state = r_state;
endmodule

// File: doc/decrypt_engine.md
# decrypt_engine

Iterative AES-128 inverse cipher (FIPS-197 §5.3), the decrypt-side counterpart of the pipelined encrypt engine. It loads a cipher key, expands it once into the 11 round keys, then decrypts one 128-bit block at a time at one round per clock. It sits beside the encrypt engine behind the accelerator's command front end. It shares the key-load, start and halt command semantics, but uses a ready/valid input handshake because it is not pipelined.

## Interface
No parameters (AES-128 fixed).

Reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- set_key  in  1  load `key`; accepted only in INIT
- key  in  128  cipher key; byte 0 in bits [127:120]
- halt  in  1  abort; drop keys, go to INIT
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  block accepted when `in_valid & in_ready`
- state  in  128  ciphertext; byte 0 in bits [127:120], column-major
- out  out  128  plaintext, same byte order
- out_valid  out  1  one-cycle pulse, `out` valid

## Operation
- FSM states: INIT, KEY_GEN, READY, BUSY.
  - INIT → KEY_GEN on `set_key`. `key` is registered as round key rk[0], and the key counter is set to 1.
  - KEY_GEN: each cycle computes rk[i] from rk[i-1] using the standard expansion (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36), then increments i. After rk[10] is written, go to READY. This takes exactly 10 cycles.
  - READY: `in_ready` = 1. On accept, register `state ^ rk[10]`, set the round counter to 9, and go to BUSY.
  - BUSY, round counter r = 9..1: data ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(data)), rk[r])), then r decrements.
  - BUSY, r = 0 (final round): `out` ← AddRoundKey(InvSubBytes(InvShiftRows(data)), rk[0]). Pulse `out_valid` and go to READY.
- Round keys are held in an 11×128 register file. Only INIT/`set_key` writes it; `rst` and `halt` zero it.
- Helper logic:
  - `addRoundKey` is the existing combinational helper.
  - New combinational leaves: inverse S-box, InvShiftRows, InvMixColumns.
  - The forward S-box is reused for SubWord.
- `in_ready` = 1 only in READY. `in_valid` is ignored in every other state.
- `set_key` is ignored outside INIT. Rekeying requires `halt` first.
- `halt` has priority over every other input in every state:
  - next state is INIT, all round keys cleared;
  - `out_valid` forced 0 next cycle;
  - an in-flight block is discarded and never output.
- `halt` in INIT: stays in INIT. Same-cycle `set_key` is ignored.
- `out` holds its last value until the next completion. It is never cleared by READY.

## Timing
- Reset values: FSM = INIT, `in_ready` = 0, `out_valid` = 0, `out` = 0, round keys = 0, both counters = 0.
- Key load: `set_key` sampled at edge E0. KEY_GEN covers edges E1..E10. READY from the cycle after E10, so `in_ready` = 1 starting 11 cycles after the `set_key` edge.
- Decrypt latency: accept at edge A. Rounds apply at A+1..A+10. `out`/`out_valid` are registered at A+10 and `out_valid` is high for the cycle following A+10.
- `in_ready` reasserts in that same cycle. A back-to-back accept at edge A+11 is legal. Throughput is 1 block per 11 cycles.
- `halt` at any edge takes effect at that edge.
- `rst` has priority over `halt`.

## Test plan
- **FIPS-197 C.1.** Key 000102030405060708090a0b0c0d0e0f, input 69c4e0d86a7b0430d8cdb78070b4c55a → `out` = 00112233445566778899aabbccddeeff. `out_valid` pulse lasts exactly 1 cycle, 11 cycles after accept.
- **Key schedule.** Key 2b7e151628aed2a6abf7158809cf4f3c: internal rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6 and `in_ready` rises 11 cycles after `set_key`. Input 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
- **Back-to-back blocks.** `in_valid` held high with the C.1 ciphertext, then the Appendix B ciphertext → two correct outputs 11 cycles apart. `in_ready` stays low during BUSY, and blocks presented while BUSY are not consumed.
- **Halt mid-decrypt.** `halt` asserted 5 cycles after accept → no `out_valid`, `in_ready` = 0, FSM in INIT. After a new `set_key` plus 11 cycles, a fresh decrypt is correct.
- **Command ignores.** Reset mid-KEY_GEN → all outputs 0. `set_key` while READY with a different key → ignored, so C.1 still decrypts correctly with the old key. `in_valid` during INIT/KEY_GEN → no output.
